bus_uart_tx: RTL



---
 rtl/bus_uart_tx.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter on the 6502 core's data bus.
//
// Register window (4 bytes at BASE_ADDR):
//   +0 DATA   write pushes a byte into the TX FIFO; reads 8'h00
//   +1 STATUS {min(count,15), overflow, busy, empty, full}; a write with bit3=1 clears overflow
//   +2 CTRL   bit0 irq_en when UART_TX_IRQ_EN is defined, otherwise reads 8'h00
//   +3        reads 8'h00, writes ignored
//
// Optional feature macro: UART_TX_IRQ_EN (CTRL register and registered drain interrupt).
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   address    bus address from the core
//   wr_data    bus write data
//   wr_enable  write strobe, one write per cycle it is high
//   rd_data    combinational read data, 8'h00 when not selected
//   sel        combinational window decode
//   txd        registered serial output, idle high
//   irq        level interrupt, tied low unless UART_TX_IRQ_EN is defined
module bus_uart_tx #(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter int          CLK_DIV   = 434,
  parameter int          FIFO_AW   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  wr_data,
  input  logic        wr_enable,
  output logic [7:0]  rd_data,
  output logic        sel,
  output logic        txd,
  output logic        irq
);

  localparam int             DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [15:0]    DIV_M1  = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [7:0]         mem_r [0:DEPTH-1];
  logic [FIFO_AW-1:0] wptr_r;
  logic [FIFO_AW-1:0] rptr_r;
  logic [FIFO_AW:0]   count_r;
  logic               overflow_r;
  state_t             state_r;
  state_t             state_s;
  logic [15:0]        baud_r;
  logic [15:0]        baud_s;
  logic [7:0]         shift_r;
  logic [7:0]         shift_s;
  logic [2:0]         idx_r;
  logic [2:0]         idx_s;
  logic               txd_r;
  logic               txd_s;
  logic               pop_s;
  logic               empty_s;
  logic               full_s;
  logic               busy_s;
  logic               push_req_s;
  logic               push_ok_s;
  logic               clr_ovf_s;
  logic [FIFO_AW+4:0] cnt_wide_s;
  logic [3:0]         cnt_sat_s;
  logic [7:0]         status_s;
  logic [7:0]         ctrl_rd_s;
  logic [7:0]         rd_data_s;

  assign sel        = (address[15:2] == BASE_ADDR[15:2]);
  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == DEPTH_C);
  assign busy_s     = (state_r != ST_IDLE);
  assign push_req_s = sel & wr_enable & (address[1:0] == 2'd0);
  // A full FIFO still accepts when the transmitter frees a slot on the same edge.
  assign push_ok_s  = push_req_s & (~full_s | pop_s);
  assign clr_ovf_s  = sel & wr_enable & (address[1:0] == 2'd1) & wr_data[3];
  assign cnt_wide_s = {4'b0000, count_r};
  assign cnt_sat_s  = (cnt_wide_s > (FIFO_AW + 5)'(15)) ? 4'hF : cnt_wide_s[3:0];
  assign status_s   = {cnt_sat_s, overflow_r, busy_s, empty_s, full_s};
  assign txd        = txd_r;
  assign rd_data    = rd_data_s;

  // Transmit FSM next-state, baud counter, shifter and serial output.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    txd_s   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rptr_r];
          baud_s  = DIV_M1;
          state_s = ST_START;
          txd_s   = 1'b0;
        end else begin
          baud_s  = 16'd0;
          txd_s   = 1'b1;
        end
      end
      ST_START: begin
        if (baud_r == 16'd0) begin
          state_s = ST_DATA;
          baud_s  = DIV_M1;
          txd_s   = shift_r[0];
          idx_s   = 3'd0;
        end else begin
          baud_s  = baud_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_r == 16'd0) begin
          baud_s = DIV_M1;
          if (idx_r == 3'd7) begin
            state_s = ST_STOP;
            txd_s   = 1'b1;
          end else begin
            // Next bit is shift_r[1] because the shifter moves on this same edge.
            shift_s = {1'b0, shift_r[7:1]};
            idx_s   = idx_r + 3'd1;
            txd_s   = shift_r[1];
          end
        end else begin
          baud_s = baud_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_r == 16'd0) begin
          if (!empty_s) begin
            // Back-to-back frame: start bit follows the stop bit with no idle gap.
            pop_s   = 1'b1;
            shift_s = mem_r[rptr_r];
            baud_s  = DIV_M1;
            state_s = ST_START;
            txd_s   = 1'b0;
          end else begin
            state_s = ST_IDLE;
            baud_s  = 16'd0;
            txd_s   = 1'b1;
          end
        end else begin
          baud_s = baud_r - 16'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        baud_s  = 16'd0;
        txd_s   = 1'b1;
      end
    endcase
  end

  // Transmit FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      txd_r   <= txd_s;
    end
  end

  // FIFO storage; contents need no reset because pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A dropped byte sets overflow even if a clear arrives on the same edge.
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

`ifdef UART_TX_IRQ_EN
  logic ctrl_r;
  logic irq_r;

  // CTRL register and drain interrupt.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_r <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      if (sel && wr_enable && (address[1:0] == 2'd2)) begin
        ctrl_r <= wr_data[0];
      end
      irq_r <= ctrl_r & empty_s & ~busy_s;
    end
  end

  assign ctrl_rd_s = {7'b0000000, ctrl_r};
  assign irq       = irq_r;
`else
  assign ctrl_rd_s = 8'h00;
  assign irq       = 1'b0;
`endif

  // Read mux; zero when deselected so it can be OR-combined with memory data.
  always_comb begin
    rd_data_s = 8'h00;
    if (sel) begin
      case (address[1:0])
        2'd1:    rd_data_s = status_s;
        2'd2:    rd_data_s = ctrl_rd_s;
        default: rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

endmodule
